ipsxe_floating_point_input_decode_round_v1_0: RTL
=================================================

Name: ipsxe_floating_point_input_decode_round_v1_0

Overview:
Front stage of the fl2fl float-to-float converter; sits directly upstream of the output encode stage. Unpacks the input float and classifies it as zero, normal, inf or NaN. When narrowing, it rounds the fraction round-to-nearest-even and resolves exponent overflow/underflow. It emits exactly the sign / frac_mid / exp_in / case_judge bundle the encode stage consumes, plus a valid flag and exception flags.

Parameters:
FLOAT_IN_EXP, 11, input exponent width
FLOAT_IN_FRAC, 53, input fraction width incl. hidden one
FLOAT_OUT_EXP, 8, output exponent width
FLOAT_OUT_FRAC, 24, output fraction width incl. hidden one
FRAC_MID_WIDTH, 24, must equal FLOAT_OUT_FRAC when narrowing (IN_FRAC>OUT_FRAC), else FLOAT_IN_FRAC-1

Ports:
i_aclk  in  1  clock
i_areset  in  1  asynchronous active-high reset
i_aclken  in  1  clock enable; all registers hold when low
i_valid  in  1  input data qualifier
i_data  in  FLOAT_IN_EXP+FLOAT_IN_FRAC  {sign, exp, frac without hidden one}
o_valid  out  1  output bundle qualifier
sign  out  1  sign passed through
frac_mid  out  FRAC_MID_WIDTH  narrowing: {round carry, OUT_FRAC-1 rounded fraction bits}; widening: raw input fraction
exp_in  out  FLOAT_IN_EXP  biased input exponent, or special code
case_judge  out  2  [0]=special, [1]=quiet-NaN fraction MSB
o_overflow  out  1  result forced to inf by range
o_underflow  out  1  result flushed to zero (subnormal in/out)
o_invalid  out  1  input was NaN

Behaviour:
- Reset: asynchronous on i_areset high; every output register, including o_valid and the flags, clears to 0 immediately. Registers update only on i_aclk edges with i_aclken=1.
- Latency: 2 enabled cycles. i_valid is piped alongside the data. Stage 1 registers the class, exponent, rounded sum and carry. Stage 2 registers the range checks and the final outputs. No backpressure; one datum per enabled cycle.
- Classes:
  - exp all ones, frac≠0 → NaN: case_judge=11, exp_in=all ones, frac_mid=0, o_invalid=1.
  - exp all ones, frac=0 → inf: case_judge=01, exp_in=all ones.
  - exp=0 (zero or subnormal) → zero: case_judge=01, exp_in=0, frac_mid=0. o_underflow=1 only if frac≠0.
  - Otherwise normal: case_judge=00.
- Special codes: exp_in all ones / all zeros, so both the MSB and bit0 carry the inf/zero selection used by the encode stage in either direction.
- Widening, normal input: frac_mid = input fraction, exp_in = input exponent. No rounding; flags are 0.
- Narrowing, normal input:
  - Fraction split: keep = top OUT_FRAC-1 bits, guard = next bit, sticky = OR of the remaining bits.
  - inc = guard & (sticky | keep[0]).
  - {carry, frac} = keep + inc, giving OUT_FRAC bits.
  - e' = exp + (OUT_BIAS − IN_BIAS), computed signed in FLOAT_IN_EXP+2 bits.
  - e' + carry ≥ 2^OUT_EXP−1 → inf code, o_overflow=1.
  - e' ≤ 0 → zero code, o_underflow=1. No subnormal outputs; flush to zero.
  - Otherwise frac_mid = {carry, frac} and exp_in = input exponent.
- Sign is always passed through, including for NaN and flushed zero.
- Simultaneous i_areset and i_aclken: reset wins.
- i_aclken low with i_valid high: the input is ignored, pipeline contents are held, o_valid is held.

Test Plan:
(All vectors use the defaults: double → single.)
- 0x3FF0000000000000 with i_valid → 2 enabled cycles later: o_valid=1, sign=0, exp_in=0x3FF, frac_mid=0x000000, case_judge=00, flags 0.
- Tie cases:
  - 0x3FF0000010000000 (guard only, lsb 0) → frac_mid=0x000000.
  - 0x3FF0000030000000 (guard with lsb 1) → frac_mid=0x000002.
- 0x3FFFFFFFF0000000 → frac_mid=0x800000 (carry), exp_in=0x3FF, case_judge=00.
- Overflow by range and by carry:
  - 0x47F0000000000000 → case_judge=01, exp_in=0x7FF, o_overflow=1.
  - 0x47EFFFFFF0000000 → same response.
- Specials and underflow:
  - 0x7FF8000000000000 → case_judge=11, o_invalid=1.
  - 0xB690000000000000 → sign=1, case_judge=01, exp_in=0, o_underflow=1.
- Enable and reset control:
  - Stream 3 valid inputs, drop i_aclken for 4 cycles mid-stream → outputs frozen, no data lost or duplicated.
  - Assert i_areset between clock edges → o_valid and all outputs go to 0 without waiting for an edge.

Source files
------------

// File: rtl/ipsxe_floating_point_input_decode_round_v1_0.sv
// Front stage of the float-to-float converter: unpacks and classifies the input,
// rounds to nearest-even when narrowing and resolves exponent range into special codes.
module ipsxe_floating_point_input_decode_round_v1_0 #(
  parameter int FLOAT_IN_EXP   = 11,
  parameter int FLOAT_IN_FRAC  = 53,
  parameter int FLOAT_OUT_EXP  = 8,
  parameter int FLOAT_OUT_FRAC = 24,
  parameter int FRAC_MID_WIDTH = 24
) (
  input  logic                                  i_aclk,
  input  logic                                  i_areset,
  input  logic                                  i_aclken,
  input  logic                                  i_valid,
  input  logic [FLOAT_IN_EXP+FLOAT_IN_FRAC-1:0] i_data,
  output logic                                  o_valid,
  output logic                                  sign,
  output logic [FRAC_MID_WIDTH-1:0]             frac_mid,
  output logic [FLOAT_IN_EXP-1:0]               exp_in,
  output logic [1:0]                            case_judge,
  output logic                                  o_overflow,
  output logic                                  o_underflow,
  output logic                                  o_invalid
);

  localparam int IE     = FLOAT_IN_EXP;
  localparam int FW     = FLOAT_IN_FRAC - 1;
  localparam int EW     = FLOAT_IN_EXP + 2;
  localparam bit NARROW = (FLOAT_IN_FRAC > FLOAT_OUT_FRAC);
  localparam int BIAS_DIFF = (2**(FLOAT_OUT_EXP-1) - 1) - (2**(FLOAT_IN_EXP-1) - 1);
  localparam logic signed [EW-1:0] BIAS_DIFF_S   = EW'(BIAS_DIFF);
  localparam logic signed [EW-1:0] OUT_EXP_MAX_S = EW'(2**FLOAT_OUT_EXP - 1);

  logic          sign_raw;
  logic [IE-1:0] exp_raw;
  logic [FW-1:0] frac_raw;
  logic          exp_ones, exp_zero, frac_nz;
  logic [FRAC_MID_WIDTH-1:0] rnd_sum;

  assign sign_raw = i_data[IE+FW];
  assign exp_raw  = i_data[IE+FW-1:FW];
  assign frac_raw = i_data[FW-1:0];
  assign exp_ones = &exp_raw;
  assign exp_zero = ~|exp_raw;
  assign frac_nz  = |frac_raw;

  // Narrowing keeps OUT_FRAC-1 bits; the sum's MSB is the rounding carry.
  if (NARROW) begin : g_narrow
    localparam int KW = FLOAT_OUT_FRAC - 1;
    localparam int GB = FW - KW - 1;
    logic [KW-1:0] keep;
    logic          guard, sticky, inc;
    assign keep    = frac_raw[FW-1 -: KW];
    assign guard   = frac_raw[GB];
    assign sticky  = |frac_raw[GB-1:0];
    assign inc     = guard & (sticky | keep[0]);
    assign rnd_sum = {1'b0, keep} + {{KW{1'b0}}, inc};
  end else begin : g_widen
    assign rnd_sum = frac_raw;
  end

  // ---- stage 1: class, exponent, rounded fraction ----
  logic vld_p1_d, sign_p1_d, nan_p1_d, inf_p1_d, zero_p1_d, sub_p1_d;
  logic vld_p1_q, sign_p1_q, nan_p1_q, inf_p1_q, zero_p1_q, sub_p1_q;
  logic [IE-1:0]             exp_p1_d, exp_p1_q;
  logic [FRAC_MID_WIDTH-1:0] sum_p1_d, sum_p1_q;

  always_comb begin
    vld_p1_d  = i_valid;
    sign_p1_d = sign_raw;
    nan_p1_d  = exp_ones & frac_nz;
    inf_p1_d  = exp_ones & ~frac_nz;
    zero_p1_d = exp_zero;
    sub_p1_d  = exp_zero & frac_nz;
    exp_p1_d  = exp_raw;
    sum_p1_d  = rnd_sum;
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      vld_p1_q  <= 1'b0;
      sign_p1_q <= 1'b0;
      nan_p1_q  <= 1'b0;
      inf_p1_q  <= 1'b0;
      zero_p1_q <= 1'b0;
      sub_p1_q  <= 1'b0;
      exp_p1_q  <= '0;
      sum_p1_q  <= '0;
    end else if (i_aclken) begin
      vld_p1_q  <= vld_p1_d;
      sign_p1_q <= sign_p1_d;
      nan_p1_q  <= nan_p1_d;
      inf_p1_q  <= inf_p1_d;
      zero_p1_q <= zero_p1_d;
      sub_p1_q  <= sub_p1_d;
      exp_p1_q  <= exp_p1_d;
      sum_p1_q  <= sum_p1_d;
    end
  end

  // ---- stage 2: range checks and final bundle ----
  logic signed [EW-1:0] e_adj, e_chk;
  logic carry_p1, ovf_rng, unf_rng;

  assign carry_p1 = NARROW & sum_p1_q[FRAC_MID_WIDTH-1];
  assign e_adj    = $signed({2'b00, exp_p1_q}) + BIAS_DIFF_S;
  assign e_chk    = e_adj + $signed({{(EW-1){1'b0}}, carry_p1});
  assign ovf_rng  = NARROW && (e_chk >= OUT_EXP_MAX_S);
  assign unf_rng  = NARROW && (e_adj[EW-1] || (e_adj == '0));

  logic vld_p2_d, sign_p2_d, ovf_p2_d, unf_p2_d, inv_p2_d;
  logic vld_p2_q, sign_p2_q, ovf_p2_q, unf_p2_q, inv_p2_q;
  logic [FRAC_MID_WIDTH-1:0] frac_p2_d, frac_p2_q;
  logic [IE-1:0]             exp_p2_d, exp_p2_q;
  logic [1:0]                cj_p2_d, cj_p2_q;

  always_comb begin
    vld_p2_d  = vld_p1_q;
    sign_p2_d = sign_p1_q;
    frac_p2_d = '0;
    exp_p2_d  = '0;
    cj_p2_d   = 2'b01;
    ovf_p2_d  = 1'b0;
    unf_p2_d  = 1'b0;
    inv_p2_d  = 1'b0;
    if (nan_p1_q) begin
      cj_p2_d  = 2'b11;
      exp_p2_d = '1;
      inv_p2_d = 1'b1;
    end else if (inf_p1_q) begin
      exp_p2_d = '1;
    end else if (zero_p1_q) begin
      unf_p2_d = sub_p1_q;
    end else if (ovf_rng) begin
      exp_p2_d = '1;
      ovf_p2_d = 1'b1;
    end else if (unf_rng) begin
      unf_p2_d = 1'b1;
    end else begin
      cj_p2_d   = 2'b00;
      exp_p2_d  = exp_p1_q;
      frac_p2_d = sum_p1_q;
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      vld_p2_q  <= 1'b0;
      sign_p2_q <= 1'b0;
      frac_p2_q <= '0;
      exp_p2_q  <= '0;
      cj_p2_q   <= '0;
      ovf_p2_q  <= 1'b0;
      unf_p2_q  <= 1'b0;
      inv_p2_q  <= 1'b0;
    end else if (i_aclken) begin
      vld_p2_q  <= vld_p2_d;
      sign_p2_q <= sign_p2_d;
      frac_p2_q <= frac_p2_d;
      exp_p2_q  <= exp_p2_d;
      cj_p2_q   <= cj_p2_d;
      ovf_p2_q  <= ovf_p2_d;
      unf_p2_q  <= unf_p2_d;
      inv_p2_q  <= inv_p2_d;
    end
  end

  assign o_valid     = vld_p2_q;
  assign sign        = sign_p2_q;
  assign frac_mid    = frac_p2_q;
  assign exp_in      = exp_p2_q;
  assign case_judge  = cj_p2_q;
  assign o_overflow  = ovf_p2_q;
  assign o_underflow = unf_p2_q;
  assign o_invalid   = inv_p2_q;

endmodule
